// File: rtl/alu_defs.sv
// Opcode constants, PSR flag bit positions and execute-stage FSM states
// shared by the ALU, its execute controller and the register file users.
package alu_defs;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_AND  = 4'b0001;
    localparam logic [3:0] OP_OR   = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_LSH  = 4'b0100;
    localparam logic [3:0] OP_ADD  = 4'b0101;
    localparam logic [3:0] OP_ADDU = 4'b0110;
    localparam logic [3:0] OP_ADDC = 4'b0111;
    localparam logic [3:0] OP_NOT  = 4'b1000;
    localparam logic [3:0] OP_SUB  = 4'b1001;
    localparam logic [3:0] OP_SUBC = 4'b1010;
    localparam logic [3:0] OP_CMP  = 4'b1011;
    localparam logic [3:0] OP_ASHU = 4'b1100;

    localparam int unsigned FLAG_Z = 4;
    localparam int unsigned FLAG_C = 3;
    localparam int unsigned FLAG_F = 2;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_L = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_WB
    } state_e;

    // Undefined opcodes fall through to 0 and therefore act as NOP.
    function automatic logic writes_reg(input logic [3:0] op);
        logic w;
        case (op)
            OP_AND, OP_OR, OP_XOR, OP_LSH, OP_ADD, OP_ADDU, OP_ADDC,
            OP_NOT, OP_SUB, OP_SUBC, OP_ASHU: w = 1'b1;
            default:                          w = 1'b0;
        endcase
        return w;
    endfunction

    function automatic logic sets_flags(input logic [3:0] op);
        logic s;
        case (op)
            OP_ADD, OP_ADDU, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP: s = 1'b1;
            default:                                           s = 1'b0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational 16-bit ALU: logic, signed-amount shifts, add/sub with carry,
// compare; flags {Z,C,F,N,L}.
module alu
    import alu_defs::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] c,
    output logic [4:0]       flags
);

    logic             add_cin;
    logic             sub_cin;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic             add_ovf;
    logic             sub_ovf;
    logic [WIDTH-1:0] shamt;

    assign add_cin = (opcode == OP_ADDC) & cin;
    assign sub_cin = (opcode == OP_SUBC) & cin;
    assign sum     = {1'b0, a} + {1'b0, b} + (WIDTH + 1)'(add_cin);
    assign diff    = {1'b0, a} - {1'b0, b} - (WIDTH + 1)'(sub_cin);
    assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
    // Shift magnitude; amounts of WIDTH or more flush the value out naturally.
    assign shamt   = b[WIDTH-1] ? (~b + 1'b1) : b;

    always_comb begin
        c     = '0;
        flags = '0;
        case (opcode)
            OP_AND: c = a & b;
            OP_OR:  c = a | b;
            OP_XOR: c = a ^ b;
            OP_NOT: c = ~a;
            OP_LSH: c = b[WIDTH-1] ? (a >> shamt) : (a << shamt);
            OP_ASHU: c = b[WIDTH-1] ? WIDTH'($signed(a) >>> shamt) : (a << shamt);
            OP_ADD, OP_ADDU, OP_ADDC: begin
                c             = sum[WIDTH-1:0];
                flags[FLAG_Z] = ~|sum[WIDTH-1:0];
                flags[FLAG_C] = sum[WIDTH];
                flags[FLAG_F] = (opcode != OP_ADDU) && add_ovf;
                flags[FLAG_N] = sum[WIDTH-1];
            end
            OP_SUB, OP_SUBC, OP_CMP: begin
                c             = diff[WIDTH-1:0];
                flags[FLAG_Z] = ~|diff[WIDTH-1:0];
                flags[FLAG_C] = diff[WIDTH];
                flags[FLAG_F] = sub_ovf;
                flags[FLAG_N] = $signed(a) < $signed(b);
                flags[FLAG_L] = a < b;
            end
            default: c = '0;
        endcase
    end

endmodule

// File: rtl/alu_exec_ctrl_regfile.sv
// Register file: synchronous write, two combinational read ports and a
// combinational debug port, synchronous clear on reset.
module regfile #(
    parameter int unsigned NREGS = 16,
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [3:0]       waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [3:0]       raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic [3:0]       raddr_b,
    output logic [WIDTH-1:0] rdata_b,
    input  logic [3:0]       dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    logic [WIDTH-1:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a  = regs[raddr_a];
    assign rdata_b  = regs[raddr_b];
    assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_exec_ctrl.sv
// Execute stage: accepts one instruction, reads operands, runs the ALU and
// writes back result and flags over a fixed IDLE -> EXEC -> WB sequence.
module alu_exec_ctrl
    import alu_defs::*;
#(
    parameter int unsigned NREGS = 16,
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [3:0]       rdest,
    input  logic [3:0]       rsrc,
    input  logic             use_imm,
    input  logic [WIDTH-1:0] imm,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       psr,
    input  logic [3:0]       dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    state_e           state;
    state_e           state_next;
    logic             accept;
    logic             load_ops;
    logic             wb;

    logic [3:0]       op_q;
    logic [3:0]       rdest_q;
    logic [3:0]       rsrc_q;
    logic             use_imm_q;
    logic [WIDTH-1:0] imm_q;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;

    logic [WIDTH-1:0] rd_a;
    logic [WIDTH-1:0] rd_b;
    logic [WIDTH-1:0] src;
    logic [WIDTH-1:0] alu_c;
    logic [4:0]       alu_flags;
    logic             rf_we;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        accept     = 1'b0;
        load_ops   = 1'b0;
        wb         = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                load_ops   = 1'b1;
                state_next = ST_WB;
            end
            ST_WB: begin
                wb         = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign src   = use_imm_q ? imm_q : rd_b;
    assign rf_we = wb && writes_reg(op_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q      <= '0;
            rdest_q   <= '0;
            rsrc_q    <= '0;
            use_imm_q <= 1'b0;
            imm_q     <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            done      <= 1'b0;
            result    <= '0;
            psr       <= '0;
        end else begin
            done <= wb;
            if (accept) begin
                op_q      <= op;
                rdest_q   <= rdest;
                rsrc_q    <= rsrc;
                use_imm_q <= use_imm;
                imm_q     <= imm;
            end
            // NOT is unary on the source operand, so it goes on the A side.
            if (load_ops) begin
                opa_q <= (op_q == OP_NOT) ? src : rd_a;
                opb_q <= src;
            end
            if (wb) begin
                result <= alu_c;
                if (sets_flags(op_q)) begin
                    psr <= alu_flags;
                end
            end
        end
    end

    regfile #(
        .NREGS(NREGS),
        .WIDTH(WIDTH)
    ) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .we      (rf_we),
        .waddr   (rdest_q),
        .wdata   (alu_c),
        .raddr_a (rdest_q),
        .rdata_a (rd_a),
        .raddr_b (rsrc_q),
        .rdata_b (rd_b),
        .dbg_addr(dbg_addr),
        .dbg_data(dbg_data)
    );

    alu #(
        .WIDTH(WIDTH)
    ) u_alu (
        .opcode(op_q),
        .a     (opa_q),
        .b     (opb_q),
        .cin   (psr[FLAG_C]),
        .c     (alu_c),
        .flags (alu_flags)
    );

endmodule
